synaptic_accumulator: RTL and testbench

Spike-to-current stage of the Izhikevich graph accelerator: it consumes the `fired` events produced by the neuron update unit and produces the per-neuron input current `i` for the next timestep. Each accepted spike walks a locally stored fan-out table (target, weight) and saturating-adds each weight into a per-target accumulator. On a step request the block streams every accumulated current out with valid/ready, clearing each entry as it goes.

---
 rtl/izh_pkg.sv | 25 ++
 rtl/sat_adder.sv | 21 ++
 rtl/synaptic_accumulator.sv | 153 +++++++++++++++
 tb/tb_synaptic_accumulator.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/izh_pkg.sv
// Shared definitions for the Izhikevich graph accelerator: datapath width,
// accumulator controller states, signed limits and a saturating add helper.
package izh_pkg;

  localparam int W = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FANOUT = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_DONE   = 2'd3
  } acc_state_t;

  localparam logic [W-1:0] SMAX = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] SMIN = {1'b1, {(W-1){1'b0}}};

  // Signed W-bit add that clamps to SMAX/SMIN instead of wrapping.
  function automatic logic [W-1:0] sat_add(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] s;
    s = {a[W-1], a} + {b[W-1], b};
    if (s[W] != s[W-1]) return s[W] ? SMIN : SMAX;
    return s[W-1:0];
  endfunction

endpackage

// File: rtl/sat_adder.sv
// W-bit signed saturating adder: overflow clamps to the most positive value,
// underflow to the most negative value.
module sat_adder #(
  parameter int W = izh_pkg::W
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);

  logic [W:0] sum;

  assign sum = {a[W-1], a} + {b[W-1], b};

  // Sign-extended sum disagreeing in its top two bits means the result left the W-bit range.
  always_comb begin
    y = sum[W-1:0];
    if (sum[W] != sum[W-1]) y = sum[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
  end

endmodule

// File: rtl/synaptic_accumulator.sv
// Spike-to-current stage: each accepted spike walks its fan-out table and
// saturating-adds the weights into per-target accumulators; a step request
// streams out and clears every accumulator.
//
// Handshakes: a beat transfers on a rising edge where valid and ready are both
// high. spike_ready does not depend on spike_valid; out_valid does not depend
// on out_ready, and out_id/out_i hold stable while out_valid && !out_ready.
module synaptic_accumulator
  import izh_pkg::*;
#(
  parameter  int N_NEURONS = 16,
  parameter  int FANOUT    = 4,
  parameter  int W         = izh_pkg::W,
  localparam int IDW       = $clog2(N_NEURONS),
  localparam int SW        = $clog2(FANOUT)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           cfg_we,
  input  logic [IDW-1:0] cfg_src,
  input  logic [SW-1:0]  cfg_slot,
  input  logic [IDW-1:0] cfg_target,
  input  logic [W-1:0]   cfg_weight,
  input  logic           spike_valid,
  input  logic [IDW-1:0] spike_id,
  output logic           spike_ready,
  input  logic           step_start,
  output logic           out_valid,
  output logic [IDW-1:0] out_id,
  output logic [W-1:0]   out_i,
  input  logic           out_ready,
  output logic           done,
  output acc_state_t     dbg_state
);

  localparam int TBL_N = N_NEURONS * FANOUT;

  logic [IDW-1:0]    tbl_target [TBL_N];
  logic [W-1:0]      tbl_weight [TBL_N];
  logic [W-1:0]      acc        [N_NEURONS];

  acc_state_t        state, next_state;
  logic [IDW-1:0]    src_q;
  logic [SW-1:0]     slot_q;
  logic [IDW-1:0]    idx_q;

  logic [IDW+SW-1:0] rd_addr;
  logic [IDW-1:0]    fo_target;
  logic [W-1:0]      fo_weight;
  logic [W-1:0]      fo_sum;
  logic              spike_hs;
  logic              out_hs;
  logic              last_slot;
  logic              last_idx;

  assign rd_addr   = {src_q, slot_q};
  assign fo_target = tbl_target[rd_addr];
  assign fo_weight = tbl_weight[rd_addr];
  assign spike_hs  = (state == ST_IDLE) && spike_valid;
  assign out_hs    = (state == ST_DRAIN) && out_ready;
  assign last_slot = (slot_q == SW'(FANOUT - 1));
  assign last_idx  = (idx_q == IDW'(N_NEURONS - 1));
  assign dbg_state = state;

  sat_adder #(.W(W)) u_sat_adder (
    .a (acc[fo_target]),
    .b (fo_weight),
    .y (fo_sum)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  // Next state: a pending spike wins over a step request in IDLE.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (spike_valid)     next_state = ST_FANOUT;
        else if (step_start) next_state = ST_DRAIN;
      end
      ST_FANOUT: if (last_slot)            next_state = ST_IDLE;
      ST_DRAIN:  if (out_ready && last_idx) next_state = ST_DONE;
      ST_DONE:   next_state = ST_IDLE;
      default:   next_state = ST_IDLE;
    endcase
  end

  // Outputs decoded from the current state; id/current forced to 0 outside DRAIN.
  always_comb begin
    spike_ready = 1'b0;
    out_valid   = 1'b0;
    out_id      = '0;
    out_i       = '0;
    done        = 1'b0;
    case (state)
      ST_IDLE:  spike_ready = 1'b1;
      ST_DRAIN: begin
        out_valid = 1'b1;
        out_id    = idx_q;
        out_i     = acc[idx_q];
      end
      ST_DONE:  done = 1'b1;
      default:  ;
    endcase
  end

  // Source latch, slot walker and drain index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      src_q  <= '0;
      slot_q <= '0;
      idx_q  <= '0;
    end else begin
      if (spike_hs) begin
        src_q  <= spike_id;
        slot_q <= '0;
      end else if (state == ST_FANOUT) begin
        slot_q <= slot_q + 1'b1;
      end
      if (state == ST_IDLE && !spike_valid && step_start) idx_q <= '0;
      else if (out_hs)                                    idx_q <= idx_q + 1'b1;
    end
  end

  // Fan-out table: writable only while IDLE, so an in-flight walk never sees a change.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < TBL_N; i++) begin
        tbl_target[i] <= '0;
        tbl_weight[i] <= '0;
      end
    end else if (state == ST_IDLE && cfg_we) begin
      tbl_target[{cfg_src, cfg_slot}] <= cfg_target;
      tbl_weight[{cfg_src, cfg_slot}] <= cfg_weight;
    end
  end

  // Accumulators: one saturating add per FANOUT cycle, clear-on-read during DRAIN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_NEURONS; i++) acc[i] <= '0;
    end else if (state == ST_FANOUT) begin
      acc[fo_target] <= fo_sum;
    end else if (out_hs) begin
      acc[idx_q] <= '0;
    end
  end

endmodule

// File: tb/tb_synaptic_accumulator.sv
// Directed bench for synaptic_accumulator with a queue-based output scoreboard.
module tb_synaptic_accumulator;
  import izh_pkg::*;

  localparam int N   = 16;
  localparam int F   = 4;
  localparam int DW  = 16;
  localparam int IDW = 4;
  localparam int SW  = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic           cfg_we;
  logic [IDW-1:0] cfg_src;
  logic [SW-1:0]  cfg_slot;
  logic [IDW-1:0] cfg_target;
  logic [DW-1:0]  cfg_weight;
  logic           spike_valid;
  logic [IDW-1:0] spike_id;
  logic           spike_ready;
  logic           step_start;
  logic           out_valid;
  logic [IDW-1:0] out_id;
  logic [DW-1:0]  out_i;
  logic           out_ready;
  logic           done;
  acc_state_t     dbg_state;

  synaptic_accumulator #(.N_NEURONS(N), .FANOUT(F), .W(DW)) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_we      (cfg_we),
    .cfg_src     (cfg_src),
    .cfg_slot    (cfg_slot),
    .cfg_target  (cfg_target),
    .cfg_weight  (cfg_weight),
    .spike_valid (spike_valid),
    .spike_id    (spike_id),
    .spike_ready (spike_ready),
    .step_start  (step_start),
    .out_valid   (out_valid),
    .out_id      (out_id),
    .out_i       (out_i),
    .out_ready   (out_ready),
    .done        (done),
    .dbg_state   (dbg_state)
  );

  // ---------------- clock / cycle count ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [IDW+DW-1:0] exp_q[$];
  logic [DW-1:0]     exp_acc [N];
  logic [IDW+DW-1:0] e;
  logic [IDW+DW-1:0] held_val;
  bit                held = 0;
  int                n_cmp = 0;
  int                n_err = 0;
  int                n_hs = 0;
  int                last_hs_cyc = -10;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Monitor: pops one expected beat per output handshake, checks hold under stall.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (held) begin
        n_cmp++;
        if ({out_id, out_i} !== held_val) begin
          n_err++;
          $display("FAIL stall_hold: got %h expected %h", {out_id, out_i}, held_val);
        end
        held = 0;
      end
      if (out_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL out_unexpected: got %h expected none", {out_id, out_i});
        end else begin
          e = exp_q.pop_front();
          if ({out_id, out_i} !== e) begin
            n_err++;
            $display("FAIL out_beat: got id %0d i %h expected id %0d i %h",
                     out_id, out_i, e[IDW+DW-1:DW], e[DW-1:0]);
          end
        end
        n_hs++;
        last_hs_cyc = cyc;
      end else begin
        held     = 1;
        held_val = {out_id, out_i};
      end
    end else begin
      held = 0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check_reset_outputs(input string tag);
    chk({tag, "_spike_ready"}, spike_ready, 1);
    chk({tag, "_out_valid"},   out_valid,   0);
    chk({tag, "_out_id"},      out_id,      0);
    chk({tag, "_out_i"},       out_i,       0);
    chk({tag, "_done"},        done,        0);
  endtask

  task automatic cfg_write(input int src, input int slot, input int tgt, input logic [DW-1:0] wt);
    cfg_src    = IDW'(src);
    cfg_slot   = SW'(slot);
    cfg_target = IDW'(tgt);
    cfg_weight = wt;
    cfg_we     = 1'b1;
    @(posedge clk); #1;
    cfg_we     = 1'b0;
  endtask

  // Issues one spike and checks spike_ready is low for exactly FANOUT cycles.
  task automatic send_spike(input int id);
    int n;
    spike_valid = 1'b1;
    spike_id    = IDW'(id);
    n = 0;
    while (!spike_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("spike_accept_wait", (n < 50), 1);
    @(posedge clk); #1;
    spike_valid = 1'b0;
    for (int k = 0; k < F; k++) begin
      chk("fanout_busy", spike_ready, 0);
      @(posedge clk); #1;
    end
    chk("fanout_return", spike_ready, 1);
  endtask

  // Moves the hand-computed current table into the scoreboard and zeroes it.
  task automatic push_exp();
    logic [IDW-1:0] idv;
    for (int i = 0; i < N; i++) begin
      idv = IDW'(i);
      exp_q.push_back({idv, exp_acc[i]});
      exp_acc[i] = '0;
    end
  endtask

  // Runs a started drain to its done pulse; bp toggles out_ready each cycle.
  task automatic finish_drain(input bit bp);
    bit seen;
    seen = 0;
    for (int c = 0; c < 200; c++) begin
      @(posedge clk); #1;
      cfg_we = 1'b0;
      if (done) begin
        seen = 1;
        break;
      end
      if (bp) out_ready = ~out_ready;
    end
    chk("done_seen", seen, 1);
    chk("done_timing", cyc, last_hs_cyc + 1);
    chk("drain_all_beats", exp_q.size(), 0);
    exp_q.delete();
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("done_one_cycle", done, 0);
    chk("idle_after_done", spike_ready, 1);
  endtask

  task automatic run_drain(input bit bp, input bit cfg_in_drain);
    push_exp();
    step_start = 1'b1;
    out_ready  = 1'b1;
    @(posedge clk); #1;
    step_start = 1'b0;
    chk("drain_valid_next", out_valid, 1);
    if (cfg_in_drain) begin
      cfg_src    = 4'd3;
      cfg_slot   = 2'd3;
      cfg_target = 4'd9;
      cfg_weight = 16'd100;
      cfg_we     = 1'b1;
    end
    finish_drain(bp);
  endtask

  task automatic write_src3_table();
    cfg_write(3, 0, 5, 16'd10);
    cfg_write(3, 1, 5, 16'd20);
    cfg_write(3, 2, 7, 16'hFFFC);
    cfg_write(3, 3, 0, 16'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int h0;
    int c;
    rst = 1'b1; cfg_we = 1'b0; cfg_src = '0; cfg_slot = '0; cfg_target = '0;
    cfg_weight = '0; spike_valid = 1'b0; spike_id = '0; step_start = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < N; i++) exp_acc[i] = '0;

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("por");
    chk("por_state", dbg_state, ST_IDLE);
    rst = 1'b0;
    @(posedge clk); #1;

    // Empty drain after reset.
    run_drain(0, 0);

    // Basic fan-out with a repeated target and a negative weight.
    write_src3_table();
    send_spike(3);
    exp_acc[5] = 16'h001E;
    exp_acc[7] = 16'hFFFC;
    run_drain(0, 0);
    run_drain(0, 0);

    // Positive and negative saturation.
    cfg_write(1, 0, 2, 16'h7000);
    send_spike(1);
    send_spike(1);
    exp_acc[2] = 16'h7FFF;
    run_drain(0, 0);
    cfg_write(1, 0, 2, 16'h9000);
    send_spike(1);
    send_spike(1);
    exp_acc[2] = 16'h8000;
    run_drain(0, 0);

    // Spike, config write and step request in the same IDLE cycle.
    cfg_src = 4'd4; cfg_slot = 2'd0; cfg_target = 4'd6; cfg_weight = 16'd7; cfg_we = 1'b1;
    spike_valid = 1'b1; spike_id = 4'd4; step_start = 1'b1;
    exp_acc[6] = 16'd7;
    push_exp();
    @(posedge clk); #1;
    cfg_we = 1'b0; spike_valid = 1'b0;
    for (int k = 0; k < F; k++) begin
      chk("race_busy", spike_ready, 0);
      chk("race_no_drain", out_valid, 0);
      @(posedge clk); #1;
    end
    chk("race_idle_again", spike_ready, 1);
    @(posedge clk); #1;
    step_start = 1'b0;
    chk("race_drain_start", out_valid, 1);
    finish_drain(0);

    // Backpressure drain with a config write attempted mid-drain.
    send_spike(3);
    exp_acc[5] = 16'h001E;
    exp_acc[7] = 16'hFFFC;
    run_drain(1, 1);
    send_spike(3);
    exp_acc[5] = 16'h001E;
    exp_acc[7] = 16'hFFFC;
    run_drain(0, 0);

    // Reset in the middle of a fan-out walk.
    spike_valid = 1'b1; spike_id = 4'd3;
    @(posedge clk); #1;
    spike_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check_reset_outputs("rst_fanout");
    @(posedge clk); #1;
    rst = 1'b0;
    send_spike(3);
    run_drain(0, 0);

    // Reset in the middle of a drain.
    write_src3_table();
    send_spike(3);
    exp_acc[5] = 16'h001E;
    exp_acc[7] = 16'hFFFC;
    push_exp();
    step_start = 1'b1;
    out_ready  = 1'b1;
    @(posedge clk); #1;
    step_start = 1'b0;
    h0 = n_hs;
    c  = 0;
    while (n_hs < h0 + 3 && c < 50) begin
      @(posedge clk); #1;
      c++;
    end
    chk("partial_drain_beats", (n_hs >= h0 + 3), 1);
    rst = 1'b1;
    #1;
    check_reset_outputs("rst_drain");
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    send_spike(3);
    run_drain(0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global time limit.
  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "time limit reached");
  end

endmodule
